adpcm_sample_seq: RTL and testbench



---
 rtl/adpcm_sample_seq_if.sv | 24 ++
 rtl/adpcm_sample_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_adpcm_sample_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpcm_sample_seq_if.sv
// CPU register bus and sample-ROM fetch bus of the ADPCM sequencer.
// master = CPU/ROM side, slave = sequencer side.
interface adpcm_sample_seq_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [1:0]            cpu_addr;
  logic [7:0]            cpu_din;
  logic                  cpu_wr;
  logic [7:0]            cpu_dout;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_req;
  logic                  rom_ack;
  logic [7:0]            rom_data;

  modport master (
    output cpu_addr, cpu_din, cpu_wr, rom_ack, rom_data,
    input  cpu_dout, rom_addr, rom_req
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_wr, rom_ack, rom_data,
    output cpu_dout, rom_addr, rom_req
  );
endinterface

// File: rtl/adpcm_sample_seq.sv
// ADPCM sample sequencer: fetches ROM bytes by page, emits nibbles (high first) one per cen_vclk, 1-clock latency.
// rom_req is a level held until rom_ack; optional irq_n output under `ADPCM_SEQ_IRQ_EN.
module adpcm_sample_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int VOL_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cen_vclk,
  adpcm_sample_seq_if.slave    bus,
  output logic [3:0]           nibble,
  output logic                 nibble_valid,
  output logic [VOL_WIDTH-1:0] volume,
`ifdef ADPCM_SEQ_IRQ_EN
  output logic                 irq_n,
`endif
  output logic                 playing
);

  localparam int PW = ADDR_WIDTH - 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HI, S_LO} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [PW-1:0]         start_pg_q, start_pg_d;
  logic [PW-1:0]         end_pg_q, end_pg_d;
  logic [VOL_WIDTH-1:0]  vol_q, vol_d;
  logic                  loop_q, loop_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic [7:0]            buf_q, buf_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  nib_vld_q, nib_vld_d;
  logic                  restart_q, restart_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  rom_req_q;
  logic                  playing_q;
  logic                  irq_n_q, irq_n_d;

  logic wr_start, wr_end, wr_vol, wr_ctrl, ctl_stop, ctl_clr, step, outstanding;
  logic [PW-1:0] din_pg;

  assign wr_start    = bus.cpu_wr && (bus.cpu_addr == 2'd0);
  assign wr_end      = bus.cpu_wr && (bus.cpu_addr == 2'd1);
  assign wr_vol      = bus.cpu_wr && (bus.cpu_addr == 2'd2);
  assign wr_ctrl     = bus.cpu_wr && (bus.cpu_addr == 2'd3);
  assign ctl_stop    = wr_ctrl && bus.cpu_din[1];
  assign ctl_clr     = wr_ctrl && bus.cpu_din[2];
  assign din_pg      = bus.cpu_din[PW-1:0];
  // Start and stop writes win over a coincident nibble step; other writes let it through.
  assign step        = cen_vclk && !(wr_start || ctl_stop);
  assign outstanding = (state_q == S_FETCH);
  assign addr_inc    = addr_q + ADDR_ONE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    start_pg_d  = start_pg_q;
    end_pg_d    = end_pg_q;
    vol_d       = vol_q;
    loop_d      = loop_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
    buf_d       = buf_q;
    nibble_d    = nibble_q;
    nib_vld_d   = 1'b0;
    restart_d   = restart_q;
    stop_pend_d = stop_pend_q;
    irq_n_d     = irq_n_q;

    if (wr_end)  end_pg_d = din_pg;
    if (wr_vol)  vol_d    = bus.cpu_din[VOL_WIDTH-1:0];
    if (wr_ctrl) loop_d   = bus.cpu_din[0];

    case (state_q)
      S_FETCH: begin
        if (cen_vclk) underrun_d = 1'b1;
        if (bus.rom_ack) begin
          restart_d   = 1'b0;
          stop_pend_d = 1'b0;
          // An ack owed to a superseded request is swallowed here.
          if (stop_pend_q) begin
            state_d = S_IDLE;
          end else if (restart_q) begin
            addr_d = {start_pg_q, 8'h00};
            if (start_pg_q == end_pg_d) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            buf_d   = bus.rom_data;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (step) begin
          nibble_d  = buf_q[7:4];
          nib_vld_d = 1'b1;
          state_d   = S_LO;
        end
      end
      S_LO: begin
        if (step) begin
          nibble_d  = buf_q[3:0];
          nib_vld_d = 1'b1;
          if (addr_inc[ADDR_WIDTH-1:8] == end_pg_d) begin
            if (loop_d) begin
              addr_d  = {start_pg_q, 8'h00};
              state_d = S_FETCH;
            end else begin
              addr_d  = addr_inc;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            addr_d  = addr_inc;
            state_d = S_FETCH;
          end
        end
      end
      default: ;
    endcase

    if (ctl_clr) begin
      done_d     = 1'b0;
      underrun_d = 1'b0;
    end

    if (wr_start) begin
      start_pg_d  = din_pg;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
      stop_pend_d = 1'b0;
      if (outstanding && !bus.rom_ack) begin
        // Keep the address stable until the in-flight request is acked.
        restart_d = 1'b1;
        state_d   = S_FETCH;
      end else begin
        restart_d = 1'b0;
        addr_d    = {din_pg, 8'h00};
        if (din_pg == end_pg_d) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
    end else if (ctl_stop) begin
      restart_d = 1'b0;
      if (outstanding && !bus.rom_ack) begin
        stop_pend_d = 1'b1;
        state_d     = S_FETCH;
      end else begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
    end

    if (wr_start || ctl_clr) irq_n_d = 1'b1;
    if (done_d && (!done_q || wr_start || ctl_clr)) irq_n_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      start_pg_q  <= '0;
      end_pg_q    <= '0;
      vol_q       <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      buf_q       <= 8'h00;
      nibble_q    <= 4'h0;
      nib_vld_q   <= 1'b0;
      restart_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      rom_req_q   <= 1'b0;
      playing_q   <= 1'b0;
      irq_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      start_pg_q  <= start_pg_d;
      end_pg_q    <= end_pg_d;
      vol_q       <= vol_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      buf_q       <= buf_d;
      nibble_q    <= nibble_d;
      nib_vld_q   <= nib_vld_d;
      restart_q   <= restart_d;
      stop_pend_q <= stop_pend_d;
      rom_req_q   <= (state_d == S_FETCH);
      playing_q   <= (state_d != S_IDLE);
      irq_n_q     <= irq_n_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.rom_req  = rom_req_q;
  assign bus.cpu_dout = {5'b00000, underrun_q, done_q, playing_q};
  assign nibble       = nibble_q;
  assign nibble_valid = nib_vld_q;
  assign volume       = vol_q;
  assign playing      = playing_q;

`ifdef ADPCM_SEQ_IRQ_EN
  assign irq_n = irq_n_q;
`else
  logic unused_irq;
  assign unused_irq = irq_n_d ^ irq_n_q;
`endif

endmodule

// File: tb/tb_adpcm_sample_seq.sv
// Directed bench for adpcm_sample_seq with a req/ack ROM model of adjustable latency.
module tb_adpcm_sample_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       cen_vclk;
  logic [3:0] nibble;
  logic       nibble_valid;
  logic [3:0] volume;
  logic       playing;
`ifdef ADPCM_SEQ_IRQ_EN
  logic       irq_n;
`endif

  adpcm_sample_seq_if #(.ADDR_WIDTH(16)) bus ();

  adpcm_sample_seq #(.ADDR_WIDTH(16), .VOL_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cen_vclk     (cen_vclk),
    .bus          (bus),
    .nibble       (nibble),
    .nibble_valid (nibble_valid),
    .volume       (volume),
`ifdef ADPCM_SEQ_IRQ_EN
    .irq_n        (irq_n),
`endif
    .playing      (playing)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rom_delay = 1;
  bit         rom_mode = 1'b0;
  logic [3:0] nq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    bus.cpu_wr   = 1'b1;
    tick();
    bus.cpu_wr   = 1'b0;
  endtask

  task automatic cen_pulse();
    cen_vclk = 1'b1;
    tick();
    cen_vclk = 1'b0;
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (5) tick();
      cen_pulse();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Expected stream: byte k/2 of the page run, byte value = low address byte.
  function automatic int seq_errs();
    int         e = 0;
    logic [7:0] b;
    logic [3:0] x;
    for (int k = 0; k < nq.size(); k++) begin
      b = 8'((k / 2) % 256);
      x = (k % 2 == 1) ? b[3:0] : b[7:4];
      if (nq[k] !== x) e++;
    end
    return e;
  endfunction

  // ROM model: acks rom_delay cycles after it first sees rom_req.
  initial begin
    int cnt = 0;
    bus.rom_ack  = 1'b0;
    bus.rom_data = 8'h00;
    forever begin
      tick();
      bus.rom_ack = 1'b0;
      if (bus.rom_req === 1'b1) begin
        if (cnt >= rom_delay) begin
          bus.rom_ack  = 1'b1;
          bus.rom_data = rom_mode ? (bus.rom_addr[7:0] ^ bus.rom_addr[15:8]) : bus.rom_addr[7:0];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) if (nibble_valid === 1'b1) nq.push_back(nibble);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    reset        = 1'b1;
    cen_vclk     = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 2'd0;
    bus.cpu_din  = 8'h00;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_dout",     bus.cpu_dout, 8'h00);
    chk("rst_req",      bus.rom_req,  1'b0);
    chk("rst_addr",     bus.rom_addr, 16'h0000);
    chk("rst_nibble",   nibble,       4'h0);
    chk("rst_nvld",     nibble_valid, 1'b0);
    chk("rst_volume",   volume,       4'h0);
    chk("rst_playing",  playing,      1'b0);
`ifdef ADPCM_SEQ_IRQ_EN
    chk("rst_irq_n",    irq_n,        1'b1);
`endif

    // One-shot play of pages 0x10..0x10.
    cpu_write(2'd1, 8'h11);
    cpu_write(2'd2, 8'h09);
    chk("volume", volume, 4'h9);
    cpu_write(2'd0, 8'h10);
    chk("start_req_lat", bus.rom_req,  1'b1);
    chk("start_addr",    bus.rom_addr, 16'h1000);
    chk("start_dout",    bus.cpu_dout, 8'h01);
    nq.delete();
    play(512);
    repeat (5) tick();
    chk("oneshot_count", nq.size(), 512);
    chk("oneshot_errs",  seq_errs(), 0);
    chk("oneshot_n1",    nq[1], 4'h0);
    chk("oneshot_n3",    nq[3], 4'h1);
    chk("oneshot_n511",  nq[511], 4'hF);
    chk("oneshot_dout",  bus.cpu_dout, 8'h02);
    chk("oneshot_play",  playing, 1'b0);
    chk("oneshot_addr",  bus.rom_addr, 16'h1100);
    chk("oneshot_req",   bus.rom_req, 1'b0);
`ifdef ADPCM_SEQ_IRQ_EN
    chk("irq_fall",      irq_n, 1'b0);
`endif
    cpu_write(2'd3, 8'h04);
    chk("clr_dout",      bus.cpu_dout, 8'h00);
`ifdef ADPCM_SEQ_IRQ_EN
    chk("irq_rise",      irq_n, 1'b1);
`endif

    // Loop mode: 600 nibbles wrap back to 0x1000 after nibble 512.
    cpu_write(2'd3, 8'h01);
    nq.delete();
    cpu_write(2'd0, 8'h10);
    play(600);
    repeat (5) tick();
    chk("loop_count", nq.size(), 600);
    chk("loop_errs",  seq_errs(), 0);
    chk("loop_n512",  nq[512], 4'h0);
    chk("loop_n513",  nq[513], 4'h0);
    chk("loop_addr",  bus.rom_addr, 16'h102C);
    chk("loop_dout",  bus.cpu_dout, 8'h01);
    cpu_write(2'd3, 8'h02);
    chk("stop_dout",  bus.cpu_dout, 8'h00);
    chk("stop_req",   bus.rom_req, 1'b0);

    // Slow ROM: cen_vclk during FETCH flags underrun, nibble holds.
    do_reset();
    rom_mode  = 1'b1;
    rom_delay = 200;
    cpu_write(2'd1, 8'h14);
    cpu_write(2'd0, 8'h12);
    nq.delete();
    repeat (100) tick();
    cen_pulse();
    chk("urun_dout",   bus.cpu_dout, 8'h05);
    chk("urun_nibble", nibble, 4'h0);
    chk("urun_nvld",   nibble_valid, 1'b0);
    repeat (150) tick();
    cen_pulse();
    chk("urun_hi",     nibble, 4'h1);
    chk("urun_hi_vld", nibble_valid, 1'b1);
    tick();
    chk("urun_vld_pulse", nibble_valid, 1'b0);
    repeat (5) tick();
    cen_pulse();
    chk("urun_lo",     nibble, 4'h2);
    chk("urun_sticky", bus.cpu_dout, 8'h05);
    rom_delay = 1;

    // Start page equal to end page: no fetch, done at once.
    do_reset();
    cpu_write(2'd1, 8'h20);
    cpu_write(2'd0, 8'h20);
    chk("eq_req",  bus.rom_req, 1'b0);
    chk("eq_dout", bus.cpu_dout, 8'h02);
    tick();
    chk("eq_req2", bus.rom_req, 1'b0);
`ifdef ADPCM_SEQ_IRQ_EN
    chk("eq_irq_n", irq_n, 1'b0);
`endif

    // Start write while a request is outstanding.
    do_reset();
    rom_delay = 20;
    cpu_write(2'd1, 8'h40);
    cpu_write(2'd2, 8'h0A);
    cpu_write(2'd0, 8'h30);
    repeat (5) tick();
    cpu_write(2'd0, 8'h25);
    chk("pend_addr_hold", bus.rom_addr, 16'h3000);
    chk("pend_req_hold",  bus.rom_req, 1'b1);
    w = 0;
    while (bus.rom_addr !== 16'h2500 && w < 100) begin
      tick();
      w++;
    end
    chk("pend_new_addr", bus.rom_addr, 16'h2500);
    chk("pend_new_req",  bus.rom_req, 1'b1);
    repeat (30) tick();
    cen_pulse();
    chk("pend_hi", nibble, 4'h2);
    repeat (3) tick();
    cen_pulse();
    chk("pend_lo",   nibble, 4'h5);
    chk("pend_dout", bus.cpu_dout, 8'h01);

    // Reset mid-play.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_req",    bus.rom_req, 1'b0);
    chk("mid_rst_addr",   bus.rom_addr, 16'h0000);
    chk("mid_rst_nibble", nibble, 4'h0);
    chk("mid_rst_volume", volume, 4'h0);
    chk("mid_rst_dout",   bus.cpu_dout, 8'h00);
    reset = 1'b0;
    tick();

    // Stop while a request is outstanding: req held until the ack, then idle.
    rom_delay = 10;
    nq.delete();
    cpu_write(2'd1, 8'h41);
    cpu_write(2'd0, 8'h40);
    repeat (3) tick();
    cpu_write(2'd3, 8'h02);
    chk("stop_pend_req", bus.rom_req, 1'b1);
    w = 0;
    while (bus.rom_req !== 1'b0 && w < 100) begin
      tick();
      w++;
    end
    chk("stop_pend_drop", bus.rom_req, 1'b0);
    chk("stop_pend_dout", bus.cpu_dout, 8'h00);
    repeat (5) tick();
    cen_pulse();
    chk("stop_pend_nonib", nq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
